// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: upstream word in, packed BCD result out.
interface bin2bcd_seq_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   bin;
  logic           out_valid;
  logic           out_ready;
  logic [4*D-1:0] bcd;
  logic           ovf;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, ovf
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready on both sides and a sticky overflow flag.
module bin2bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   io
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bin_q,   bin_d;
  logic [4*D-1:0] dig_q,   dig_d;
  logic           ovf_q,   ovf_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [4*D-1:0] corr;

  // Add-3 corrections are all taken from the pre-shift digits.
  always_comb begin
    corr = dig_q;
    for (int unsigned i = 0; i < D; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) corr[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          bin_d   = io.bin;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Bit shifted out of the top digit means the value needs more than D digits.
        dig_d = {corr[4*D-2:0], bin_q[W-1]};
        bin_d = bin_q << 1;
        ovf_d = ovf_q | corr[4*D-1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.bcd       = dig_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: a 3-digit and a 2-digit converter run in lockstep on shared stimulus.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] bin = '0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.W(8), .D(3)) if3 ();
  bin2bcd_seq_if #(.W(8), .D(2)) if2 ();

  assign if3.in_valid  = in_valid;
  assign if3.bin       = bin;
  assign if3.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.bin       = bin;
  assign if2.out_ready = out_ready;

  bin2bcd_seq #(.W(8), .D(3)) u_d3 (.clk(clk), .rst_n(rst_n), .io(if3));
  bin2bcd_seq #(.W(8), .D(2)) u_d2 (.clk(clk), .rst_n(rst_n), .io(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion with handoff; expectations derived arithmetically from v.
  task automatic conv(input int v, input bit check_d2);
    int n;
    logic [11:0] e3;
    logic [7:0]  e2;
    bit nib_ok;
    bin = 8'(v);
    in_valid = 1'b1;
    chk("idle_in_ready", 32'(if3.in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("busy_in_ready", 32'(if3.in_ready), 32'd0);
    n = 0;
    while (!if3.out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    e3 = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    chk("bcd_d3", 32'(if3.bcd), 32'(e3));
    chk("ovf_d3", 32'(if3.ovf), 32'd0);
    nib_ok = (if3.bcd[3:0] <= 4'd9) && (if3.bcd[7:4] <= 4'd9) && (if3.bcd[11:8] <= 4'd9);
    chk("nibble_range", 32'(nib_ok), 32'd1);
    if (check_d2) begin
      e2 = {4'(v / 10 % 10), 4'(v % 10)};
      chk("bcd_d2", 32'(if2.bcd), 32'(e2));
      chk("ovf_d2", 32'(if2.ovf), 32'(v > 99));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_idle", 32'(if3.in_ready), 32'd1);
  endtask

  int vals[4];
  int got_cnt;
  int last_cyc;
  int cyc;
  int idx;
  bit prev_rdy;
  bit bad;

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(if3.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if3.out_valid), 32'd0);
    chk("rst_bcd", 32'(if3.bcd), 32'h000);
    chk("rst_ovf", 32'(if3.ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_in_ready_hold", 32'(if3.in_ready), 32'd1);
    chk("idle_out_valid_hold", 32'(if3.out_valid), 32'd0);
    chk("idle_bcd_hold", 32'(if3.bcd), 32'h000);

    // Single conversion and edge values (D=2 overflow cases ride along)
    conv(255, 1'b0);
    chk("bcd_255", 32'(if3.bcd), 32'h255);
    conv(0, 1'b1);
    conv(9, 1'b1);
    conv(10, 1'b1);
    conv(99, 1'b1);
    chk("d2_99", 32'({if2.ovf, if2.bcd}), 32'h099);
    conv(100, 1'b1);
    chk("d2_100", 32'({if2.ovf, if2.bcd}), 32'h100);
    conv(123, 1'b1);
    chk("d2_123", 32'({if2.ovf, if2.bcd}), 32'h123);
    conv(200, 1'b1);
    chk("bcd_200", 32'(if3.bcd), 32'h200);

    // Full sweep
    for (int v = 0; v < 256; v++) conv(v, 1'b1);

    // Backpressure: result held, input side ignored
    bin = 8'd42;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("bp_valid", 32'(if3.out_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bin = 8'd200;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      chk("bp_out_valid", 32'(if3.out_valid), 32'd1);
      chk("bp_bcd", 32'(if3.bcd), 32'h042);
      chk("bp_in_ready", 32'(if3.in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(if3.in_ready), 32'd1);
    chk("bp_release_valid", 32'(if3.out_valid), 32'd0);

    // Asynchronous reset mid-conversion
    bin = 8'd77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(if3.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(if3.out_valid), 32'd0);
    chk("mid_rst_bcd", 32'(if3.bcd), 32'h000);
    chk("mid_rst_ovf", 32'(if3.ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if3.out_valid || !if3.in_ready) bad = 1'b1;
    end
    chk("no_partial_result", 32'(bad), 32'd0);

    // Back-to-back stream with out_ready held high
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 0;
    out_ready = 1'b1;
    idx = 0;
    bin = 8'(vals[0]);
    in_valid = 1'b1;
    prev_rdy = if3.in_ready;
    got_cnt = 0;
    last_cyc = 0;
    cyc = 0;
    while (got_cnt < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (prev_rdy && in_valid) begin
        idx++;
        bin = 8'(vals[idx]);
        if (idx == 3) in_valid = 1'b0;
      end
      prev_rdy = if3.in_ready;
      if (if3.out_valid) begin
        chk("stream_bcd", 32'(if3.bcd), 32'(got_cnt + 1));
        if (got_cnt > 0) chk("stream_spacing", 32'(cyc - last_cyc), 32'd10);
        last_cyc = cyc;
        got_cnt++;
      end
    end
    chk("stream_count", 32'(got_cnt), 32'd3);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
